// File: rtl/alu_host_driver_if.sv
// Pin-level ALU host channel: command in, pin buses to/from the ALU, response out.
// slave = the host driver itself, master = whatever issues commands and models the ALU pins.
interface alu_host_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;
  logic [1:0] cmd_c;
  logic [1:0] cmd_opcode;
  logic [1:0] cmd_inmode;
  logic [7:0] pin_ui_out;
  logic [7:0] pin_uio_out;
  logic [7:0] pin_uo_in;
  logic [7:0] pin_uio_in;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [9:0] rsp_result;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_c, cmd_opcode, cmd_inmode,
    output cmd_ready,
    output pin_ui_out, pin_uio_out,
    input  pin_uo_in, pin_uio_in,
    output rsp_valid, rsp_result,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_c, cmd_opcode, cmd_inmode,
    input  cmd_ready,
    input  pin_ui_out, pin_uio_out,
    output pin_uo_in, pin_uio_in,
    input  rsp_valid, rsp_result,
    output rsp_ready
  );
endinterface

// File: rtl/alu_host_driver.sv
// Host-side driver of the ALU pin protocol: one command at a time is packed onto the pins,
// the result is sampled LATENCY edges later and returned on a valid/ready response channel.
module alu_host_driver #(
  parameter int LATENCY = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_host_driver_if.slave host,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [7:0]       r_ui;
  logic [7:0]       r_uio;
  logic [9:0]       r_result;
  logic [CNT_W-1:0] r_txn;
  logic             w_accept;
  logic             w_sample;
  logic             w_done;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (host.cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_sample    = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (host.rsp_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pins hold the last accepted command until the next accept; result holds until replaced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd0;
      r_ui     <= 8'd0;
      r_uio    <= 8'd0;
      r_result <= 10'd0;
      r_txn    <= '0;
    end else begin
      if (w_accept) begin
        r_ui  <= {host.cmd_a, host.cmd_b};
        r_uio <= {2'b00, host.cmd_c, host.cmd_opcode, host.cmd_inmode};
        r_cnt <= LAT_M1;
      end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_sample) r_result <= {host.pin_uio_in[7:6], host.pin_uo_in};
      if (w_done)   r_txn    <= r_txn + CNT_W'(1);
    end
  end

  assign host.cmd_ready   = (r_state == S_IDLE);
  assign host.rsp_valid   = (r_state == S_RESP);
  assign host.rsp_result  = r_result;
  assign host.pin_ui_out  = r_ui;
  assign host.pin_uio_out = r_uio;
  assign busy             = (r_state != S_IDLE);
  assign txn_count        = r_txn;

endmodule

// File: tb/tb_alu_host_driver.sv
// Bench for alu_host_driver: one instance at LATENCY=2/CNT_W=16, one at LATENCY=1/CNT_W=4.
module tb_alu_host_driver;

  logic        clk;
  logic        rst;
  logic        busy_a, busy_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  alu_host_driver_if ifa ();
  alu_host_driver_if ifb ();

  alu_host_driver #(.LATENCY(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .host(ifa.slave), .busy(busy_a), .txn_count(cnt_a));

  alu_host_driver #(.LATENCY(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .host(ifb.slave), .busy(busy_b), .txn_count(cnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a, b;
    logic [1:0] c, op, im;
    logic [7:0] uo, uio;
    logic [7:0] ui_e, uio_e;
    logic [9:0] res_e;
  } vec_t;

  vec_t vecs [5];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_cnt_a = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on dut_a; correct ALU pins are only present around the sample edge T+2.
  task automatic run_a(input int i);
    vec_t v;
    v = vecs[i];
    check("a_ready_before", 32'(ifa.cmd_ready), 1);
    ifa.cmd_valid = 1'b1;  ifa.cmd_a = v.a;  ifa.cmd_b = v.b;
    ifa.cmd_c = v.c;  ifa.cmd_opcode = v.op;  ifa.cmd_inmode = v.im;
    ifa.rsp_ready = 1'b1;
    ifa.pin_uo_in = ~v.uo;  ifa.pin_uio_in = ~v.uio;
    tick();
    ifa.cmd_valid = 1'b0;  ifa.cmd_a = ~v.a;  ifa.cmd_b = ~v.b;
    check("a_pin_ui", 32'(ifa.pin_ui_out), 32'(v.ui_e));
    check("a_pin_uio", 32'(ifa.pin_uio_out), 32'(v.uio_e));
    check("a_busy", 32'(busy_a), 1);
    check("a_ready_wait", 32'(ifa.cmd_ready), 0);
    tick();
    check("a_rsp_valid_early", 32'(ifa.rsp_valid), 0);
    ifa.pin_uo_in = v.uo;  ifa.pin_uio_in = v.uio;
    tick();
    ifa.pin_uo_in = ~v.uo;  ifa.pin_uio_in = ~v.uio;
    check("a_rsp_valid", 32'(ifa.rsp_valid), 1);
    check("a_rsp_result", 32'(ifa.rsp_result), 32'(v.res_e));
    tick();
    exp_cnt_a++;
    check("a_rsp_valid_done", 32'(ifa.rsp_valid), 0);
    check("a_ready_after", 32'(ifa.cmd_ready), 1);
    check("a_txn_count", 32'(cnt_a), 32'(exp_cnt_a[15:0]));
    check("a_pin_ui_hold", 32'(ifa.pin_ui_out), 32'(v.ui_e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a:4'h3, b:4'h5, c:2'd1, op:2'd2, im:2'd3, uo:8'hA5, uio:8'hC0,
                ui_e:8'h35, uio_e:8'h1B, res_e:10'h3A5};
    vecs[1] = '{a:4'hF, b:4'h0, c:2'd3, op:2'd0, im:2'd1, uo:8'h00, uio:8'h7F,
                ui_e:8'hF0, uio_e:8'h31, res_e:10'h100};
    vecs[2] = '{a:4'h0, b:4'hF, c:2'd0, op:2'd3, im:2'd0, uo:8'hFF, uio:8'h3F,
                ui_e:8'h0F, uio_e:8'h0C, res_e:10'h0FF};
    vecs[3] = '{a:4'hA, b:4'hC, c:2'd2, op:2'd1, im:2'd2, uo:8'h5A, uio:8'h80,
                ui_e:8'hAC, uio_e:8'h26, res_e:10'h25A};
    vecs[4] = '{a:4'h7, b:4'h8, c:2'd3, op:2'd3, im:2'd3, uo:8'h3C, uio:8'hFF,
                ui_e:8'h78, uio_e:8'h3F, res_e:10'h33C};

    rst = 1'b1;
    ifa.cmd_valid = 1'b0; ifa.cmd_a = '0; ifa.cmd_b = '0; ifa.cmd_c = '0;
    ifa.cmd_opcode = '0; ifa.cmd_inmode = '0; ifa.pin_uo_in = '0; ifa.pin_uio_in = '0;
    ifa.rsp_ready = 1'b0;
    ifb.cmd_valid = 1'b0; ifb.cmd_a = '0; ifb.cmd_b = '0; ifb.cmd_c = '0;
    ifb.cmd_opcode = '0; ifb.cmd_inmode = '0; ifb.pin_uo_in = '0; ifb.pin_uio_in = '0;
    ifb.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Post-reset state
    check("rst_ready", 32'(ifa.cmd_ready), 1);
    check("rst_rsp_valid", 32'(ifa.rsp_valid), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_txn", 32'(cnt_a), 0);
    tick();

    for (int i = 0; i < 5; i++) run_a(i);

    // Asynchronous reset between clock edges
    #2 rst = 1'b1;
    #2;
    check("arst_ready", 32'(ifa.cmd_ready), 1);
    check("arst_rsp_valid", 32'(ifa.rsp_valid), 0);
    check("arst_result", 32'(ifa.rsp_result), 0);
    check("arst_pin_ui", 32'(ifa.pin_ui_out), 0);
    check("arst_pin_uio", 32'(ifa.pin_uio_out), 0);
    check("arst_busy", 32'(busy_a), 0);
    check("arst_txn", 32'(cnt_a), 0);
    #2 rst = 1'b0;
    exp_cnt_a = 0;
    tick();

    // Backpressure on the response channel
    ifa.cmd_valid = 1'b1; ifa.cmd_a = 4'h3; ifa.cmd_b = 4'h5; ifa.cmd_c = 2'd1;
    ifa.cmd_opcode = 2'd2; ifa.cmd_inmode = 2'd3; ifa.rsp_ready = 1'b0;
    ifa.pin_uo_in = 8'hA5; ifa.pin_uio_in = 8'hC0;
    tick();
    ifa.cmd_valid = 1'b0;
    check("bp_pin_ui", 32'(ifa.pin_ui_out), 32'h35);
    check("bp_pin_uio", 32'(ifa.pin_uio_out), 32'h1B);
    tick();
    tick();
    check("bp_rsp_valid", 32'(ifa.rsp_valid), 1);
    check("bp_result", 32'(ifa.rsp_result), 32'h3A5);
    ifa.pin_uo_in = 8'h12; ifa.pin_uio_in = 8'h00;
    ifa.cmd_valid = 1'b1; ifa.cmd_a = 4'h9;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_hold_result", 32'(ifa.rsp_result), 32'h3A5);
      check("bp_hold_valid", 32'(ifa.rsp_valid), 1);
      check("bp_hold_ready", 32'(ifa.cmd_ready), 0);
    end
    ifa.cmd_valid = 1'b0;
    ifa.rsp_ready = 1'b1;
    tick();
    check("bp_done_valid", 32'(ifa.rsp_valid), 0);
    check("bp_done_txn", 32'(cnt_a), 1);
    check("bp_done_ready", 32'(ifa.cmd_ready), 1);
    check("bp_pin_ui_hold", 32'(ifa.pin_ui_out), 32'h35);
    exp_cnt_a = 1;

    // cmd_valid held high with a changing operand: accepts every LATENCY+2 cycles
    begin
      logic [3:0] exp_a;
      exp_a = 4'h0;
      ifa.cmd_b = 4'h2; ifa.cmd_c = 2'd0; ifa.cmd_opcode = 2'd1; ifa.cmd_inmode = 2'd0;
      for (int k = 0; k < 12; k++) begin
        ifa.cmd_valid = 1'b1;
        ifa.cmd_a = 4'(k + 1);
        check("held_ready", 32'(ifa.cmd_ready), 32'((k % 4) == 0));
        tick();
        if ((k % 4) == 0) exp_a = 4'(k + 1);
        check("held_pin_a", 32'(ifa.pin_ui_out[7:4]), 32'(exp_a));
      end
      ifa.cmd_valid = 1'b0;
      exp_cnt_a += 3;
      check("held_txn", 32'(cnt_a), 32'(exp_cnt_a));
    end

    // Reset while waiting on the ALU
    ifa.cmd_valid = 1'b1; ifa.cmd_a = 4'h0; ifa.cmd_b = 4'hF; ifa.cmd_c = 2'd0;
    ifa.cmd_opcode = 2'd3; ifa.cmd_inmode = 2'd0;
    tick();
    ifa.cmd_valid = 1'b0;
    check("mid_busy", 32'(busy_a), 1);
    #2 rst = 1'b1;
    #2;
    check("mid_rsp_valid", 32'(ifa.rsp_valid), 0);
    check("mid_pin_ui", 32'(ifa.pin_ui_out), 0);
    check("mid_pin_uio", 32'(ifa.pin_uio_out), 0);
    check("mid_txn", 32'(cnt_a), 0);
    #2 rst = 1'b0;
    exp_cnt_a = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_rsp", 32'(ifa.rsp_valid), 0);
    end
    run_a(3);

    // LATENCY=1, CNT_W=4: 17 back-to-back transactions, counter wraps to 1
    check("b_txn_start", 32'(cnt_b), 0);
    check("b_ready_start", 32'(ifb.cmd_ready), 1);
    ifb.rsp_ready = 1'b1;
    for (int j = 0; j < 17; j++) begin
      logic [7:0] uo_j, uio_j, ui_e, uio_e;
      logic [9:0] res_e;
      uo_j  = 8'(j * 37 + 5);
      uio_j = {2'(j + 3), 6'(j * 5)};
      ifb.cmd_valid = 1'b1;
      ifb.cmd_a = 4'(j);  ifb.cmd_b = ~4'(j);
      ifb.cmd_c = 2'(j);  ifb.cmd_opcode = 2'(j + 1);  ifb.cmd_inmode = 2'(j + 2);
      ui_e  = {4'(j), ~4'(j)};
      uio_e = {2'b00, 2'(j), 2'(j + 1), 2'(j + 2)};
      res_e = {2'(j + 3), uo_j};
      ifb.pin_uo_in = ~uo_j;  ifb.pin_uio_in = ~uio_j;
      tick();
      ifb.pin_uo_in = uo_j;  ifb.pin_uio_in = uio_j;
      check("b_pin_ui", 32'(ifb.pin_ui_out), 32'(ui_e));
      check("b_pin_uio", 32'(ifb.pin_uio_out), 32'(uio_e));
      check("b_rsp_valid_early", 32'(ifb.rsp_valid), 0);
      tick();
      ifb.pin_uo_in = ~uo_j;  ifb.pin_uio_in = ~uio_j;
      check("b_rsp_valid", 32'(ifb.rsp_valid), 1);
      check("b_result", 32'(ifb.rsp_result), 32'(res_e));
      tick();
      check("b_ready_after", 32'(ifb.cmd_ready), 1);
      check("b_txn", 32'(cnt_b), 32'((j + 1) % 16));
    end
    ifb.cmd_valid = 1'b0;
    tick();
    check("b_txn_wrap", 32'(cnt_b), 1);
    check("b_idle", 32'(busy_b), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
